// File: rtl/fir_out_quantizer_if.sv
// Bundle of the quantizer's input strobe, output handshake, occupancy and flag signals.
// Latency: none (wires only).
// Backpressure: the output side uses valid/ready; the input side is strobe-only.
interface fir_out_quantizer_if #(
  parameter int InWidth  = 38,
  parameter int OutWidth = 16,
  parameter int Depth    = 8
);
  logic                     inValid;
  logic [InWidth-1:0]       din;
  logic                     outValid;
  logic                     outReady;
  logic [OutWidth-1:0]      dout;
  logic [$clog2(Depth):0]   count;
  logic                     clrFlags;
  logic                     satFlag;
  logic                     dropFlag;

  // Upstream/consumer side: drives samples and the ready, observes results.
  modport master (
    output inValid, din, outReady, clrFlags,
    input  outValid, dout, count, satFlag, dropFlag
  );

  // Quantizer side.
  modport slave (
    input  inValid, din, outReady, clrFlags,
    output outValid, dout, count, satFlag, dropFlag
  );
endinterface

// File: rtl/fir_out_quantizer.sv
// Scales (>>> Shift), optionally rounds, saturates FIR results and buffers them in a FWFT FIFO.
// Latency: 3 edges from inValid to the head of an empty FIFO; one sample per cycle.
// Backpressure: none toward the FIR; a full FIFO drops the sample and sets dropFlag. Build option: FIR_ROUND_EN.
module fir_out_quantizer #(
  parameter int InWidth  = 38,
  parameter int OutWidth = 16,
  parameter int Shift    = 15,
  parameter int Depth    = 8
) (
  input logic              clk,
  input logic              rst,
  fir_out_quantizer_if.slave bus
);

  localparam int QW = InWidth + 1 - Shift;            // width of the shifted value
  localparam int CW = (QW > OutWidth) ? QW : OutWidth; // common width for the clip compare
  localparam int AW = $clog2(Depth);

  localparam logic signed [CW-1:0] SAT_MAX = {{(CW-OutWidth+1){1'b0}}, {(OutWidth-1){1'b1}}};
  localparam logic signed [CW-1:0] SAT_MIN = {{(CW-OutWidth+1){1'b1}}, {(OutWidth-1){1'b0}}};
  localparam logic [OutWidth-1:0]  OUT_MAX = {1'b0, {(OutWidth-1){1'b1}}};
  localparam logic [OutWidth-1:0]  OUT_MIN = {1'b1, {(OutWidth-1){1'b0}}};
  localparam logic [AW:0]          FULL    = (AW+1)'(Depth);

  // ---------------- S1: optional rounding bias and arithmetic shift ----------------
  logic signed [InWidth:0] din_ext;
  logic signed [InWidth:0] r_val;
  logic                    s1_vld;
  logic signed [QW-1:0]    s1_q;

  // One extra bit of headroom so the rounding add can never wrap.
  assign din_ext = {bus.din[InWidth-1], bus.din};

`ifdef FIR_ROUND_EN
  localparam logic [InWidth:0] BIAS = (InWidth+1)'(1) << (Shift-1);
  assign r_val = din_ext + $signed(BIAS);
`else
  assign r_val = din_ext;
`endif

  // Capture the shifted value; dropping the low Shift bits of r is r >>> Shift.
  always_ff @(posedge clk) begin
    if (rst) s1_vld <= 1'b0;
    else     s1_vld <= bus.inValid;
    if (bus.inValid) s1_q <= r_val[InWidth:Shift];
  end

  // ---------------- S2: saturate to OutWidth ----------------
  logic signed [CW-1:0]  q_ext;
  logic                  sat_hi;
  logic                  sat_lo;
  logic [OutWidth-1:0]   sat_val;
  logic                  s2_vld;
  logic                  s2_sat;
  logic [OutWidth-1:0]   s2_dat;

  assign q_ext   = CW'(s1_q);
  assign sat_hi  = q_ext > SAT_MAX;
  assign sat_lo  = q_ext < SAT_MIN;
  assign sat_val = sat_hi ? OUT_MAX : (sat_lo ? OUT_MIN : q_ext[OutWidth-1:0]);

  // Register the clipped sample with its clip indication; bubbles carry through s2_vld.
  always_ff @(posedge clk) begin
    if (rst) s2_vld <= 1'b0;
    else     s2_vld <= s1_vld;
    if (s1_vld) begin
      s2_dat <= sat_val;
      s2_sat <= sat_hi | sat_lo;
    end
  end

  // ---------------- FIFO (first-word-fall-through) ----------------
  logic [OutWidth-1:0] mem [Depth];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         cnt;
  logic                pop;
  logic                push;
  logic                sat_evt;
  logic                drop_evt;
  logic                sat_flag;
  logic                drop_flag;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign pop      = (cnt != '0) && bus.outReady;
  assign push     = s2_vld && ((cnt != FULL) || pop);
  assign sat_evt  = s2_vld && s2_sat;
  assign drop_evt = s2_vld && !push;

  // Storage is left unreset; only valid entries are ever exposed on dout.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s2_dat;
  end

  // Pointers wrap naturally at the power-of-two depth; simultaneous push/pop holds cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (!push && pop) cnt <= cnt - 1'b1;
    end
  end

  // Sticky flags: a set event in the same cycle beats the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag  <= 1'b0;
      drop_flag <= 1'b0;
    end else begin
      if (sat_evt)           sat_flag  <= 1'b1;
      else if (bus.clrFlags) sat_flag  <= 1'b0;
      if (drop_evt)          drop_flag <= 1'b1;
      else if (bus.clrFlags) drop_flag <= 1'b0;
    end
  end

  assign bus.outValid = (cnt != '0);
  assign bus.dout     = (cnt != '0) ? mem[rd_ptr] : '0;
  assign bus.count    = cnt;
  assign bus.satFlag  = sat_flag;
  assign bus.dropFlag = drop_flag;

endmodule

// File: tb/tb_fir_out_quantizer.sv
// Randomized and directed bench for fir_out_quantizer against a queue-based reference model.
// Latency: checks every cycle on the falling edge.
// Backpressure: outReady is driven randomly and in directed full/drain sequences.
module tb_fir_out_quantizer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_out_quantizer_if #(.InWidth(38), .OutWidth(16), .Depth(8)) bus ();

  fir_out_quantizer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Bench-owned stimulus, mirrored onto the interface.
  logic        in_valid  = 1'b0;
  logic [37:0] din_r     = '0;
  logic        out_ready = 1'b0;
  logic        clr       = 1'b0;

  assign bus.inValid  = in_valid;
  assign bus.din      = din_r;
  assign bus.outReady = out_ready;
  assign bus.clrFlags = clr;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
    else
      n_pass++;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] val;
    bit          sat;
    int          due;
  } flight_t;

  flight_t     inflight[$];
  logic [15:0] fq[$];
  bit          m_sat  = 1'b0;
  bit          m_drop = 1'b0;
  int          cyc    = 0;

  // Plain integer arithmetic: scale by 2^-15, optional half-up rounding, clip to int16.
  task automatic ref_quant(input logic [37:0] d, output logic [15:0] v, output bit s);
    longint x;
    x = longint'($signed(d));
`ifdef FIR_ROUND_EN
    x = x + 64'sd16384;
`endif
    x = x >>> 15;
    s = 1'b0;
    if (x > 64'sd32767) begin
      x = 64'sd32767;
      s = 1'b1;
    end else if (x < -64'sd32768) begin
      x = -64'sd32768;
      s = 1'b1;
    end
    v = x[15:0];
  endtask

  // Applied once per rising edge with the inputs the DUT sees at that edge.
  task automatic model_edge();
    bit          pop, have, ok, s;
    logic [15:0] v;
    flight_t     f;
    cyc++;
    if (rst) begin
      inflight.delete();
      fq.delete();
      m_sat  = 1'b0;
      m_drop = 1'b0;
      return;
    end
    pop  = (fq.size() != 0) && out_ready;
    have = (inflight.size() != 0) && (inflight[0].due == cyc);
    if (have) f = inflight.pop_front();
    ok = have && ((fq.size() < 8) || pop);
    if (pop) void'(fq.pop_front());
    if (ok) fq.push_back(f.val);
    if (have && f.sat)   m_sat = 1'b1;
    else if (clr)        m_sat = 1'b0;
    if (have && !ok)     m_drop = 1'b1;
    else if (clr)        m_drop = 1'b0;
    if (in_valid) begin
      ref_quant(din_r, v, s);
      inflight.push_back('{val: v, sat: s, due: cyc + 2});
    end
  endtask

  task automatic compare_all();
    check("outValid", 64'(bus.outValid), 64'(fq.size() != 0));
    check("dout",     64'(bus.dout),     64'((fq.size() != 0) ? fq[0] : 16'h0000));
    check("count",    64'(bus.count),    64'(fq.size()));
    check("satFlag",  64'(bus.satFlag),  64'(m_sat));
    check("dropFlag", 64'(bus.dropFlag), 64'(m_drop));
  endtask

  // Drive one cycle of inputs (called on a falling edge), clock it, then compare.
  task automatic step(input logic iv = 1'b0, input logic [37:0] d = '0,
                      input logic ordy = 1'b1, input logic c = 1'b0, input logic r = 1'b0);
    in_valid  = iv;
    din_r     = d;
    out_ready = ordy;
    clr       = c;
    rst       = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [37:0] kq(input int k);
    return 38'(k * 32768);
  endfunction

  logic [15:0] exp_pos_round;
  logic [15:0] exp_neg_round;

  initial begin
`ifdef FIR_ROUND_EN
    exp_pos_round = 16'h0002;
    exp_neg_round = 16'hFFFF;
`else
    exp_pos_round = 16'h0001;
    exp_neg_round = 16'hFFFE;
`endif
    @(negedge clk);

    // Reset state (inValid during reset is ignored).
    step(1'b1, 38'h12345, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("rst_outValid", 64'(bus.outValid), 64'd0);
    check("rst_dout",     64'(bus.dout),     64'd0);
    check("rst_count",    64'(bus.count),    64'd0);
    check("rst_flags",    64'({bus.satFlag, bus.dropFlag}), 64'd0);
    step();
    step();
    check("rst_noghost", 64'(bus.outValid), 64'd0);

    // Basic path: head appears 3 edges after the input edge, for one cycle.
    step(1'b1, 38'h00_0040_0000);
    step();
    step();
    check("basic_vld",  64'(bus.outValid), 64'd1);
    check("basic_dout", 64'(bus.dout),     64'h0080);
    step();
    check("basic_one",  64'(bus.outValid), 64'd0);

    // Rounding of +/-1.5 in Q15.
    step(1'b1, 38'd49152);
    step();
    step();
    check("round_pos", 64'(bus.dout), 64'(exp_pos_round));
    step(1'b1, 38'h3F_FFFF_4000);
    step();
    step();
    check("round_neg", 64'(bus.dout), 64'(exp_neg_round));
    step();

    // Saturation and flag clear behaviour.
    step(1'b1, 38'h00_8000_0000);
    step();
    step();
    check("sat_pos",  64'(bus.dout),    64'h7FFF);
    check("sat_flag", 64'(bus.satFlag), 64'd1);
    step(1'b1, 38'h3F_8000_0000);
    step();
    step();
    check("sat_neg",  64'(bus.dout),    64'h8000);
    step();
    step(1'b0, '0, 1'b1, 1'b1);
    check("sat_clr",  64'(bus.satFlag), 64'd0);
    step(1'b1, 38'h00_8000_0000);
    step();
    step(1'b0, '0, 1'b1, 1'b1);
    check("sat_clr_vs_set", 64'(bus.satFlag), 64'd1);
    step();

    // Full FIFO with the consumer stalled: 10 samples, 8 kept, 2 dropped.
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 10; k++) step(1'b1, kq(k), 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    check("full_count", 64'(bus.count),    64'd8);
    check("full_drop",  64'(bus.dropFlag), 64'd1);
    for (int k = 1; k <= 8; k++) begin
      check("drain_order", 64'(bus.dout), 64'(k));
      step(1'b0, '0, 1'b1);
    end
    check("drain_vld",  64'(bus.outValid), 64'd0);
    check("drain_dout", 64'(bus.dout),     64'd0);

    // Full with simultaneous pop: occupancy holds at 8 across pointer wrap.
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      step(1'b1, kq(i + 1), (i >= 10));
      if (i >= 10) check("fullpop_count", 64'(bus.count), 64'd8);
    end
    check("fullpop_drop", 64'(bus.dropFlag), 64'd0);
    for (int i = 0; i < 12; i++) step();

    // Reset with 5 buffered and 2 in flight.
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, kq(i + 1), 1'b0);
    check("pre_rst_count", 64'(bus.count), 64'd5);
    step(1'b1, kq(9), 1'b0, 1'b0, 1'b1);
    check("midrst_count", 64'(bus.count),    64'd0);
    check("midrst_vld",   64'(bus.outValid), 64'd0);
    check("midrst_flags", 64'({bus.satFlag, bus.dropFlag}), 64'd0);
    step(1'b1, kq(3));
    step();
    step();
    check("post_rst_dout", 64'(bus.dout), 64'd3);
    step();
    step();
    check("post_rst_empty", 64'(bus.outValid), 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [37:0] d;
      logic [63:0] w;
      longint      t;
      case ($urandom_range(0, 3))
        0: begin
          w = {$urandom, $urandom};
          d = w[37:0];
        end
        1: begin
          t = longint'($signed($urandom)) >>> $urandom_range(0, 16);
          d = t[37:0];
        end
        2: begin
          t = longint'($urandom_range(0, 200)) - 64'sd100;
          t = t * 64'sd32768 + (($urandom_range(0, 1) == 1) ? 64'sd16384 : -64'sd16384);
          d = t[37:0];
        end
        default: begin
          t = longint'($signed($urandom)) >>> 8;
          d = t[37:0];
        end
      endcase
      step(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
    end
    for (int i = 0; i < 12; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
